// File: rtl/load_wb_unit_if.sv
// Bundle of the load/writeback unit's request, data-memory and register-file signals.
// The 'slave' modport is the unit itself. The 'master' modport is the environment,
// which covers the decode stage, data memory and register file.
// Ports: req_* (decoded load in), mem_* (word read to memory), wen/waddr/wdata (rf write), err, busy.
interface load_wb_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_rd;

    logic                  mem_rd_valid;
    logic                  mem_rd_ready;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_rdata_valid;
    logic                  mem_rdata_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  err;
    logic                  busy;

    modport slave (
        input  req_valid, req_addr, req_funct3, req_rd,
        input  mem_rd_ready, mem_rdata_valid, mem_rdata,
        output req_ready, mem_rd_valid, mem_addr, mem_rdata_ready,
        output wen, waddr, wdata, err, busy
    );

    modport master (
        output req_valid, req_addr, req_funct3, req_rd,
        output mem_rd_ready, mem_rdata_valid, mem_rdata,
        input  req_ready, mem_rd_valid, mem_addr, mem_rdata_ready,
        input  wen, waddr, wdata, err, busy
    );
endinterface

// File: rtl/load_wb_unit.sv
// Load/writeback stage: one RISC-V load at a time, word read from memory, byte/half extract + extend, one rf write.
// Latency: accept edge -> REQ -> WAIT -> WB; wen 3 cycles after accept, plus one per memory stall cycle; 4 cycles/load minimum.
// Backpressure: req_ready only in IDLE; mem_rd_valid held until mem_rd_ready; WAIT holds until mem_rdata_valid.
// Ports: clk, rst (async active-low), bus (load_wb_unit_if.slave: req_*, mem_*, wen/waddr/wdata, err, busy).
module load_wb_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    load_wb_unit_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

    state_t                state_q;
    logic [2:0]            funct3_q;
    logic [1:0]            addr_lo_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  req_ready_q;
    logic                  mem_rd_valid_q;
    logic                  mem_rdata_ready_q;
    logic [DATA_WIDTH-1:0] mem_addr_q;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic                  busy_q;

    logic                  legal_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    // Alignment rules: halves need addr[0]=0, words need addr[1:0]=0.
    always_comb begin
        legal_d = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b100: legal_d = 1'b1;
            3'b001, 3'b101: legal_d = ~bus.req_addr[0];
            3'b010:         legal_d = (bus.req_addr[1:0] == 2'b00);
            default:        legal_d = 1'b0;
        endcase
    end

    // Extraction uses only the latched offset/funct3, so req_* may change freely after accept.
    always_comb begin
        byte_sel = bus.mem_rdata[{addr_lo_q, 3'b000} +: 8];
        half_sel = bus.mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
        wdata_d  = bus.mem_rdata;
        case (funct3_q)
            3'b000:  wdata_d = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  wdata_d = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  wdata_d = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  wdata_d = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: wdata_d = bus.mem_rdata;
        endcase
    end

    // Handshake outputs are registered alongside the state so each is exactly one state's decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= S_IDLE;
            funct3_q          <= 3'b000;
            addr_lo_q         <= 2'b00;
            rd_q              <= '0;
            req_ready_q       <= 1'b1;
            mem_rd_valid_q    <= 1'b0;
            mem_rdata_ready_q <= 1'b0;
            mem_addr_q        <= '0;
            wen_q             <= 1'b0;
            waddr_q           <= '0;
            wdata_q           <= '0;
            err_q             <= 1'b0;
            busy_q            <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        if (!legal_d) begin
                            // Rejected loads never leave IDLE.
                            err_q <= 1'b1;
                        end else begin
                            funct3_q       <= bus.req_funct3;
                            addr_lo_q      <= bus.req_addr[1:0];
                            rd_q           <= bus.req_rd;
                            mem_addr_q     <= {bus.req_addr[DATA_WIDTH-1:2], 2'b00};
                            req_ready_q    <= 1'b0;
                            mem_rd_valid_q <= 1'b1;
                            busy_q         <= 1'b1;
                            state_q        <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_rd_ready) begin
                        mem_rd_valid_q    <= 1'b0;
                        mem_rdata_ready_q <= 1'b1;
                        state_q           <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rdata_valid) begin
                        mem_rdata_ready_q <= 1'b0;
                        wdata_q           <= wdata_d;
                        waddr_q           <= rd_q;
                        // x0 is hardwired zero: spend the WB cycle but suppress the write.
                        wen_q             <= (rd_q != '0);
                        state_q           <= S_WB;
                    end
                end
                S_WB: begin
                    wen_q       <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.mem_rd_valid    = mem_rd_valid_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_rdata_ready = mem_rdata_ready_q;
    assign bus.wen             = wen_q;
    assign bus.waddr           = waddr_q;
    assign bus.wdata           = wdata_q;
    assign bus.err             = err_q;
    assign bus.busy            = busy_q;
endmodule

// File: tb/tb_load_wb_unit.sv
// Testbench for load_wb_unit: directed loads with hand-computed results.
// Stimulus pushes expected writes/errors/memory addresses; a monitor and a memory responder pop and compare.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_load_wb_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    load_wb_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    load_wb_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } wb_t;

    wb_t         exp_wb[$];
    int          exp_err[$];
    logic [31:0] exp_addr[$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;

    logic [31:0] mem_word  = 32'h0;
    int          rd_stall  = 0;
    int          rdata_lat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: register-file writes, error pulses, handshake exclusivity.
    initial begin
        wb_t w;
        int  e;
        int  n;
        forever begin
            @(negedge clk);
            n = int'(bus.mem_rd_valid) + int'(bus.mem_rdata_ready) + int'(bus.wen);
            check("handshake_mutex", {31'b0, (n > 1)}, 32'h0);
            if (bus.wen) begin
                if (exp_wb.size() == 0) begin
                    check("unexpected_wen_waddr", {27'b0, bus.waddr}, 32'hFFFF_FFFF);
                end else begin
                    w = exp_wb.pop_front();
                    check("wb_waddr", {27'b0, bus.waddr}, {27'b0, w.rd});
                    check("wb_wdata", bus.wdata, w.data);
                    check("wb_cycle", cyc, w.cyc);
                end
            end
            if (bus.err) begin
                if (exp_err.size() == 0) begin
                    check("unexpected_err", 32'h1, 32'h0);
                end else begin
                    e = exp_err.pop_front();
                    check("err_cycle", cyc, e);
                end
            end
        end
    end

    // Memory model: ready after rd_stall cycles, data after rdata_lat cycles of WAIT.
    initial begin
        logic [31:0] a;
        bus.mem_rd_ready    = 1'b0;
        bus.mem_rdata_valid = 1'b0;
        bus.mem_rdata       = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.mem_rd_valid) begin
                if (exp_addr.size() == 0) begin
                    check("unexpected_mem_rd", bus.mem_addr, 32'hFFFF_FFFF);
                    a = bus.mem_addr;
                end else begin
                    a = exp_addr.pop_front();
                    check("mem_addr", bus.mem_addr, a);
                end
                for (int i = 0; i < rd_stall; i++) begin
                    @(negedge clk);
                    check("mem_rd_valid_held", {31'b0, bus.mem_rd_valid}, 32'h1);
                    check("mem_addr_stable", bus.mem_addr, a);
                end
                bus.mem_rd_ready = 1'b1;
                @(negedge clk);
                bus.mem_rd_ready = 1'b0;
                for (int i = 0; i < rdata_lat; i++) @(negedge clk);
                bus.mem_rdata       = mem_word;
                bus.mem_rdata_valid = 1'b1;
                @(negedge clk);
                bus.mem_rdata_valid = 1'b0;
                bus.mem_rdata       = 32'hA5A5_A5A5;
            end
        end
    end

    // Issue one request at a falling edge; returns at the falling edge where req_ready is back.
    task automatic issue(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] word, input int rs, input int rl,
                         input bit legal, input logic [31:0] exp_data);
        int c0;
        int lim;
        c0             = cyc;
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.req_funct3 = f3;
        bus.req_rd     = rd;
        mem_word       = word;
        rd_stall       = rs;
        rdata_lat      = rl;
        if (legal) begin
            exp_addr.push_back({addr[31:2], 2'b00});
            if (rd != 5'd0) exp_wb.push_back('{rd, exp_data, c0 + 3 + rs + rl});
        end else begin
            exp_err.push_back(c0 + 1);
        end
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_funct3 = 3'b111;
        bus.req_rd     = 5'h1F;
        lim = 0;
        while (!bus.req_ready && lim < 60) begin
            @(negedge clk);
            lim++;
        end
        if (lim >= 60) check("ready_timeout", 32'h1, 32'h0);
        else check("ready_return_cycles", cyc - c0, legal ? 4 + rs + rl : 1);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_funct3 = 3'b000;
        bus.req_rd     = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_wen", {31'b0, bus.wen}, 32'h0);
        check("rst_mem_rd_valid", {31'b0, bus.mem_rd_valid}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_req_ready", {31'b0, bus.req_ready}, 32'h1);
        check("rel_err", {31'b0, bus.err}, 32'h0);
        check("rel_mem_rdata_ready", {31'b0, bus.mem_rdata_ready}, 32'h0);
        check("rel_mem_addr", bus.mem_addr, 32'h0);
        check("rel_wdata", bus.wdata, 32'h0);
        check("rel_waddr", {27'b0, bus.waddr}, 32'h0);

        //    addr          f3      rd     word           rs rl legal expected
        issue(32'h0000_0100, 3'b010, 5'd5, 32'hDEAD_BEEF, 0, 0, 1, 32'hDEAD_BEEF);
        issue(32'h0000_0203, 3'b000, 5'd6, 32'h8011_2233, 0, 0, 1, 32'hFFFF_FF80);
        issue(32'h0000_0203, 3'b100, 5'd7, 32'h8011_2233, 0, 0, 1, 32'h0000_0080);
        issue(32'h0000_0202, 3'b001, 5'd8, 32'h8001_7777, 0, 0, 1, 32'hFFFF_8001);
        issue(32'h0000_0202, 3'b101, 5'd9, 32'h8001_7777, 0, 0, 1, 32'h0000_8001);
        issue(32'h0000_0101, 3'b001, 5'd3, 32'h0,         0, 0, 0, 32'h0);
        issue(32'h0000_0100, 3'b011, 5'd3, 32'h0,         0, 0, 0, 32'h0);
        issue(32'h0000_0102, 3'b010, 5'd3, 32'h0,         0, 0, 0, 32'h0);
        issue(32'h0000_0104, 3'b110, 5'd3, 32'h0,         0, 0, 0, 32'h0);
        issue(32'h0000_0400, 3'b010, 5'd10, 32'hCAFE_F00D, 3, 2, 1, 32'hCAFE_F00D);
        issue(32'h0000_0500, 3'b010, 5'd0, 32'h1234_5678, 0, 0, 1, 32'h0);
        issue(32'h0000_0200, 3'b000, 5'd11, 32'h0000_007F, 0, 0, 1, 32'h0000_007F);
        issue(32'h0000_0200, 3'b001, 5'd12, 32'h1234_ABCD, 0, 0, 1, 32'hFFFF_ABCD);
        issue(32'h0000_0201, 3'b000, 5'd13, 32'h0000_9A00, 0, 1, 1, 32'hFFFF_FF9A);

        // Reset while waiting for read data: load abandoned, late data ignored.
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h0000_0300;
        bus.req_funct3 = 3'b010;
        bus.req_rd     = 5'd9;
        mem_word       = 32'h55AA_55AA;
        rd_stall       = 0;
        rdata_lat      = 5;
        exp_addr.push_back(32'h0000_0300);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_in_wait", {31'b0, bus.mem_rdata_ready}, 32'h1);
        check("pre_rst_busy", {31'b0, bus.busy}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", {31'b0, bus.busy}, 32'h0);
        check("arst_mem_rdata_ready", {31'b0, bus.mem_rdata_ready}, 32'h0);
        check("arst_mem_addr", bus.mem_addr, 32'h0);
        check("arst_wdata", bus.wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_busy", {31'b0, bus.busy}, 32'h0);
            check("post_rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
            check("post_rst_wen", {31'b0, bus.wen}, 32'h0);
        end

        issue(32'h0000_0600, 3'b010, 5'd14, 32'h0BAD_F00D, 1, 0, 1, 32'h0BAD_F00D);

        repeat (4) @(negedge clk);
        check("left_wb", exp_wb.size(), 32'h0);
        check("left_err", exp_err.size(), 32'h0);
        check("left_addr", exp_addr.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/load_wb_unit.md
# load_wb_unit

Load/writeback stage of the RISC-V core, directly upstream of the register file. Accepts one decoded load per request, issues a word-aligned read to data memory over a valid/ready handshake, extracts and sign- or zero-extends the addressed byte/halfword/word, and drives the register file write port (`wen`/`waddr`/`wdata`) for exactly one cycle. Handles one load at a time; misaligned or illegal loads are rejected with an error pulse and never touch memory or the register file.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data and address width
- `ADDR_WIDTH`, 5, register index width

Ports:
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: asynchronous, active-low reset
- `req_valid` in 1: load request present
- `req_ready` out 1: unit can accept a request (high only in IDLE)
- `req_addr` in DATA_WIDTH: byte address
- `req_funct3` in 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
- `req_rd` in ADDR_WIDTH: destination register
- `mem_rd_valid` out 1: memory read request
- `mem_rd_ready` in 1: memory accepts read
- `mem_addr` out DATA_WIDTH: `{addr[31:2], 2'b00}`
- `mem_rdata_valid` in 1: read data present
- `mem_rdata_ready` out 1: unit accepts read data
- `mem_rdata` in DATA_WIDTH: read word
- `wen` out 1: register file write enable
- `waddr` out ADDR_WIDTH: register file write index
- `wdata` out DATA_WIDTH: register file write data
- `err` out 1: one-cycle pulse, rejected request
- `busy` out 1: state != IDLE

## Operation
- States: IDLE, REQ, WAIT, WB.
- IDLE: `req_ready`=1. On `req_valid`: if funct3 illegal, or LH/LHU with `addr[0]`=1, or LW with `addr[1:0]`!=0 -> `err`=1 next cycle, stay IDLE. Otherwise latch addr, funct3, rd -> REQ.
- REQ: `mem_rd_valid`=1, `mem_addr` stable from latched addr. Transfer when `mem_rd_valid & mem_rd_ready` -> WAIT. `mem_rd_valid` never drops before transfer.
- WAIT: `mem_rdata_ready`=1. On `mem_rdata_valid` latch extracted data -> WB. `mem_rdata_valid` outside WAIT is ignored.
- Extraction: byte = `mem_rdata[8*addr[1:0] +: 8]`; half = `mem_rdata[16*addr[1] +: 16]`; LB/LH sign-extend, LBU/LHU zero-extend, LW passes word.
- WB: `wen`=1 for exactly one cycle with `waddr`=latched rd, `wdata`=extracted value; -> IDLE. If rd==0, `wen` stays 0 (WB still occupies one cycle).
- `mem_rd_valid`, `mem_rdata_ready`, `wen` mutually exclusive; each a decode of state.

## Timing
- Reset (`rst`=0, any time, asynchronous): state IDLE; `req_ready`=1 after release, all other outputs 0 (`wen`, `err`, `busy`, `mem_rd_valid`, `mem_rdata_ready`=0; `waddr`, `wdata`, `mem_addr`=0). Reset in REQ/WAIT abandons the load; no register write occurs; a later stray `mem_rdata_valid` is ignored.
- Best-case latency: request accepted at edge 0 -> REQ in cycle 1 -> WAIT cycle 2 -> WB cycle 3; `wen` high in cycle 3 (3 cycles after accept). Each stall cycle of `mem_rd_ready` or `mem_rdata_valid` adds one cycle.
- Back-to-back: next request accepted in the cycle after WB (IDLE); minimum 4 cycles per load.
- `err` asserted the cycle after the rejected request's accept edge; rejected requests back-to-back give consecutive `err` pulses.
- Inputs `req_*` sampled only on IDLE accept; changes afterward have no effect.

## Test plan
- LW addr 0x100, rd=5, memory ready immediately, rdata 0xDEADBEEF -> `mem_addr`=0x100, `wen`=1 in cycle 3 with `waddr`=5, `wdata`=0xDEADBEEF.
- LB addr 0x203, rdata 0x80112233 -> `wdata`=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x202 rdata 0x8001xxxx -> 0xFFFF8001; LHU -> 0x00008001.
- LH addr 0x101 and funct3=011 -> `err` pulse each, `mem_rd_valid` never asserted, `wen` stays 0, `req_ready` stays 1.
- LW with `mem_rd_ready` low 3 cycles and `mem_rdata_valid` late 2 cycles -> `mem_rd_valid` held, `mem_addr` stable, `wen` in cycle 8, single pulse.
- LW rd=0, rdata 0x12345678 -> no `wen`; unit returns to IDLE after 4 cycles.
- `rst` low while in WAIT, then `mem_rdata_valid` pulsed after release -> outputs at reset values, no `wen`, `busy`=0.
